// File: rtl/frame_stream_buffer.sv
// Generic first-word-fall-through FIFO used as the elastic store.
// Latency: a push at edge N is visible on pop_dat after edge N.
// Backpressure: push_rdy drops only when full; pop_vld drops only when empty.
module fsb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    input  logic                     pop_rdy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (level != FULL_LVL);
    assign pop_vld  = (level != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end
endmodule

// Frame-aware elastic buffer: realigns to SOP and enforces the frame pixel count.
// Latency: one cycle from accepted input beat to visible output beat.
// Backpressure: ready_out depends only on occupancy, never on ready_in.
module frame_stream_buffer #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int DATA_WIDTH   = 12,
    parameter int DEPTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic                    startofpacket_in,
    input  logic                    endofpacket_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    ready_out,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic                    startofpacket_out,
    output logic                    endofpacket_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [31:0]             pixel_count_out,
    output logic [15:0]             frame_count_out,
    output logic                    frame_error,
    output logic [$clog2(DEPTH):0]  fill_level
);
    localparam logic [31:0] NPIX = 32'(IMAGE_WIDTH * IMAGE_HEIGHT);

    typedef enum logic {
        WAIT_SOP = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] dat;
    } beat_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pix_cnt_nxt;
    logic [15:0] frm_cnt_nxt;
    logic        err_nxt;
    logic [31:0] cnt_new;
    logic        accept;
    logic        wr_vld;
    logic        frame_end;
    beat_t       wr_beat;
    beat_t       rd_beat;

    assign accept = valid_in && ready_out;

    always_comb begin
        state_nxt   = state;
        pix_cnt_nxt = pixel_count_out;
        frm_cnt_nxt = frame_count_out;
        err_nxt     = 1'b0;
        wr_vld      = 1'b0;
        frame_end   = 1'b0;
        cnt_new     = pixel_count_out + 32'd1;
        wr_beat.sop = startofpacket_in;
        wr_beat.eop = endofpacket_in;
        wr_beat.dat = data_in;

        if (accept) begin
            if (startofpacket_in) begin
                // An SOP always opens a fresh frame; inside a frame it also flags the truncation.
                wr_vld      = 1'b1;
                cnt_new     = 32'd1;
                err_nxt     = (state == IN_FRAME);
                state_nxt   = IN_FRAME;
            end else if (state == IN_FRAME) begin
                wr_vld      = 1'b1;
            end

            if (wr_vld) begin
                pix_cnt_nxt = cnt_new;
                frame_end   = endofpacket_in || (cnt_new == NPIX);
            end

            if (frame_end) begin
                wr_beat.eop = 1'b1;
                if (!endofpacket_in || (cnt_new != NPIX)) begin
                    err_nxt = 1'b1;
                end
                frm_cnt_nxt = frame_count_out + 16'd1;
                state_nxt   = WAIT_SOP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= WAIT_SOP;
            pixel_count_out <= '0;
            frame_count_out <= '0;
            frame_error     <= 1'b0;
        end else begin
            state           <= state_nxt;
            pixel_count_out <= pix_cnt_nxt;
            frame_count_out <= frm_cnt_nxt;
            frame_error     <= err_nxt;
        end
    end

    fsb_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push_vld (wr_vld),
        .push_dat (wr_beat),
        .push_rdy (ready_out),
        .pop_vld  (valid_out),
        .pop_dat  (rd_beat),
        .pop_rdy  (ready_in),
        .level    (fill_level)
    );

    assign startofpacket_out = rd_beat.sop;
    assign endofpacket_out   = rd_beat.eop;
    assign data_out          = rd_beat.dat;
endmodule

// File: tb/tb_frame_stream_buffer.sv
module tb_frame_stream_buffer;
    localparam int W     = 9;
    localparam int H     = 7;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int NPIX  = W * H;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic          startofpacket_in;
    logic          endofpacket_in;
    logic [DW-1:0] data_in;
    logic          ready_out;
    logic          ready_in;
    logic          valid_out;
    logic          startofpacket_out;
    logic          endofpacket_out;
    logic [DW-1:0] data_out;
    logic [31:0]   pixel_count_out;
    logic [15:0]   frame_count_out;
    logic          frame_error;
    logic [LW-1:0] fill_level;

    frame_stream_buffer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_in          (valid_in),
        .startofpacket_in  (startofpacket_in),
        .endofpacket_in    (endofpacket_in),
        .data_in           (data_in),
        .ready_out         (ready_out),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .data_out          (data_out),
        .pixel_count_out   (pixel_count_out),
        .frame_count_out   (frame_count_out),
        .frame_error       (frame_error),
        .fill_level        (fill_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] dat;
    } beat_t;

    // Reference model: queue of beats the buffer should hold, plus frame bookkeeping.
    beat_t       q[$];
    bit          m_in_frame;
    int          m_cnt;
    logic [15:0] m_frames;
    bit          m_err;

    int checks = 0;
    int errors = 0;
    int err_seen;
    int max_fill;
    bit saw_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_in_frame = 1'b0;
        m_cnt      = 0;
        m_frames   = '0;
        m_err      = 1'b0;
    endtask

    task automatic model_accept(input bit sop, input bit eop, input logic [DW-1:0] dat);
        beat_t b;
        bit    keep;
        keep = 1'b0;
        if (sop) begin
            if (m_in_frame) m_err = 1'b1;
            m_in_frame = 1'b1;
            m_cnt      = 1;
            keep       = 1'b1;
        end else if (m_in_frame) begin
            m_cnt = m_cnt + 1;
            keep  = 1'b1;
        end
        if (keep) begin
            b.sop = sop;
            b.eop = eop;
            b.dat = dat;
            if (eop || m_cnt == NPIX) begin
                if (!(eop && m_cnt == NPIX)) m_err = 1'b1;
                b.eop      = 1'b1;
                m_frames   = m_frames + 16'd1;
                m_in_frame = 1'b0;
            end
            q.push_back(b);
        end
    endtask

    // Checks outputs mid-cycle, then advances the model across the next rising edge.
    task automatic cycle(output bit acc);
        bit pop;
        @(negedge clk);
        chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data_out", 32'(data_out), 32'(q[0].dat));
            chk("sop_out", 32'(startofpacket_out), 32'(q[0].sop));
            chk("eop_out", 32'(endofpacket_out), 32'(q[0].eop));
        end
        chk("ready_out", 32'(ready_out), 32'(q.size() != DEPTH));
        chk("fill_level", 32'(fill_level), 32'(q.size()));
        chk("pixel_count", pixel_count_out, 32'(m_cnt));
        chk("frame_count", 32'(frame_count_out), 32'(m_frames));
        chk("frame_error", 32'(frame_error), 32'(m_err));
        if (frame_error === 1'b1) err_seen++;
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
        if (ready_out === 1'b0) saw_full = 1'b1;
        acc   = valid_in && (q.size() != DEPTH);
        pop   = (q.size() != 0) && ready_in;
        m_err = 1'b0;
        if (pop) void'(q.pop_front());
        if (acc) model_accept(startofpacket_in, endofpacket_in, data_in);
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready high, 1 toggle, 2 random, 3 held low
    task automatic send(input int n, input int sop_at, input int eop_at,
                        input int rmode, input bit vrand);
        bit            acc;
        int            i;
        int            guard;
        logic [DW-1:0] cur;
        i     = 0;
        guard = 0;
        cur   = DW'($urandom);
        while (i < n && guard < 5000) begin
            guard++;
            valid_in         = vrand ? 1'($urandom_range(0, 1)) : 1'b1;
            startofpacket_in = (i == sop_at);
            endofpacket_in   = (i == eop_at);
            data_in          = cur;
            case (rmode)
                0:       ready_in = 1'b1;
                1:       ready_in = ~ready_in;
                2:       ready_in = 1'($urandom_range(0, 1));
                default: ready_in = 1'b0;
            endcase
            cycle(acc);
            if (acc) begin
                i++;
                cur = DW'($urandom);
            end
        end
        valid_in         = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in   = 1'b0;
        if (guard >= 5000) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit acc;
        int g;
        g        = 0;
        ready_in = 1'b1;
        valid_in = 1'b0;
        do begin
            cycle(acc);
            g++;
        end while ((q.size() != 0 || m_err) && g < 200);
        if (g >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset            = 1'b1;
        valid_in         = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in   = 1'b0;
        data_in          = '0;
        ready_in         = 1'b1;
        model_reset();
        #12;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_pixels", pixel_count_out, 32'd0);
        chk("rst_frames", 32'(frame_count_out), 32'd0);
        chk("rst_error", 32'(frame_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Clean frame, sink always ready
        err_seen = 0;
        send(NPIX, 0, NPIX - 1, 0, 1'b0);
        drain();
        chk("t1_frames", 32'(frame_count_out), 32'd1);
        chk("t1_pixels", pixel_count_out, 32'd63);
        chk("t1_errors", 32'(err_seen), 32'd0);

        // Sink ready toggling every cycle, source always valid
        max_fill = 0;
        saw_full = 1'b0;
        ready_in = 1'b0;
        send(NPIX, 0, NPIX - 1, 1, 1'b0);
        drain();
        chk("t2_max_fill", 32'(max_fill), 32'd8);
        chk("t2_saw_full", 32'(saw_full), 32'd1);
        chk("t2_frames", 32'(frame_count_out), 32'd2);

        // Leading beats without SOP are swallowed
        send(3, -1, -1, 0, 1'b0);
        chk("t3_junk_dropped", 32'(fill_level), 32'd0);
        send(NPIX, 0, NPIX - 1, 0, 1'b0);
        drain();
        chk("t3_frames", 32'(frame_count_out), 32'd3);

        // Early EOP
        err_seen = 0;
        send(41, 0, 40, 0, 1'b0);
        drain();
        chk("t4_errors", 32'(err_seen), 32'd1);
        chk("t4_frames", 32'(frame_count_out), 32'd4);
        chk("t4_pixels", pixel_count_out, 32'd41);

        // Missing EOP: forced at NPIX, overflow beats dropped, then a good frame
        err_seen = 0;
        send(70, 0, -1, 0, 1'b0);
        drain();
        chk("t5_errors", 32'(err_seen), 32'd1);
        chk("t5_frames", 32'(frame_count_out), 32'd5);
        chk("t5_pixels", pixel_count_out, 32'd63);
        send(NPIX, 0, NPIX - 1, 2, 1'b1);
        drain();
        chk("t5_next_frames", 32'(frame_count_out), 32'd6);
        chk("t5_next_errors", 32'(err_seen), 32'd1);

        // Random traffic with sporadic framing marks
        for (int k = 0; k < 400; k++) begin
            valid_in         = 1'($urandom_range(0, 1));
            startofpacket_in = ($urandom_range(0, 29) == 0);
            endofpacket_in   = ($urandom_range(0, 29) == 0);
            data_in          = DW'($urandom);
            ready_in         = 1'($urandom_range(0, 1));
            cycle(acc);
        end
        drain();

        // Asynchronous reset mid-frame with five beats buffered
        send(5, 0, -1, 3, 1'b0);
        chk("t6_pre_fill", 32'(fill_level), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid_out", 32'(valid_out), 32'd0);
        chk("t6_fill", 32'(fill_level), 32'd0);
        chk("t6_ready_out", 32'(ready_out), 32'd1);
        chk("t6_pixels", pixel_count_out, 32'd0);
        chk("t6_frames", 32'(frame_count_out), 32'd0);
        chk("t6_error", 32'(frame_error), 32'd0);
        model_reset();
        ready_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        err_seen = 0;
        send(5, -1, -1, 0, 1'b0);
        send(NPIX, 0, NPIX - 1, 0, 1'b0);
        drain();
        chk("t6_after_frames", 32'(frame_count_out), 32'd1);
        chk("t6_after_errors", 32'(err_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
